// File: rtl/cnn_div_seq_21s_7s_if.sv
// Operand/result bundle for the sequential 21s/7s divider: start handshake in,
// status strobes and signed results out.
interface cnn_div_seq_21s_7s_if;
  logic        ap_start;
  logic [20:0] dividend;
  logic [6:0]  divisor;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [13:0] quotient;
  logic [6:0]  remainder;
  logic        div_by_zero;
  logic        ovf;

  modport master (
    output ap_start, dividend, divisor,
    input  ap_ready, ap_idle, ap_done, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  ap_start, dividend, divisor,
    output ap_ready, ap_idle, ap_done, quotient, remainder, div_by_zero, ovf
  );
endinterface

// File: rtl/cnn_div_seq_21s_7s.sv
// Sequential signed divider, 21-bit dividend / 7-bit divisor, restoring, fixed latency.
// Define CNN_DIV_SAT_EN to saturate the 14-bit quotient (and flag ovf) instead of wrapping.
module cnn_div_seq_21s_7s #(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  cnn_div_seq_21s_7s_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'd20;

  // ID is an instance tag only; this empty block keeps it referenced.
  if (ID == 32'd0) begin : g_id_tag_zero
  end

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [20:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient magnitude
  logic [6:0]  rem_q, rem_d;       // partial remainder magnitude
  logic [7:0]  dvs_q, dvs_d;       // divisor magnitude (holds 64 exactly)
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;

  logic [13:0] quotient_q, quotient_d;
  logic [6:0]  remainder_q, remainder_d;
  logic        div_by_zero_q, div_by_zero_d;
  logic        ovf_q, ovf_d;

  logic [21:0] dvd_mag;
  logic [7:0]  dvs_mag;
  logic [7:0]  trial;
  logic        qbit;
`ifdef CNN_DIV_SAT_EN
  logic signed [21:0] q_full;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    neg_q_d       = neg_q_q;
    neg_r_d       = neg_r_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    ovf_d         = ovf_q;
`ifdef CNN_DIV_SAT_EN
    q_full        = neg_q_q ? 22'sd0 - $signed({1'b0, dvd_q}) : $signed({1'b0, dvd_q});
`endif

    dvd_mag = bus.dividend[20] ? 22'd0 - {1'b1, bus.dividend} : {1'b0, bus.dividend};
    dvs_mag = bus.divisor[6]   ? 8'd0  - {1'b1, bus.divisor}  : {1'b0, bus.divisor};
    trial   = {rem_q, dvd_q[20]};
    qbit    = (trial >= dvs_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          state_d = S_CALC;
          cnt_d   = 5'd0;
          dvd_d   = dvd_mag[20:0];
          // Bits above the 21-bit window seed the partial remainder.
          rem_d   = {6'd0, dvd_mag[21]};
          dvs_d   = dvs_mag;
          neg_q_d = bus.dividend[20] ^ bus.divisor[6];
          neg_r_d = bus.dividend[20];
          dz_d    = (bus.divisor == 7'd0);
        end
      end
      S_CALC: begin
        dvd_d = {dvd_q[19:0], qbit};
        rem_d = 7'(trial - (qbit ? dvs_q : 8'd0));
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (dz_q) begin
          quotient_d    = 14'd0;
          remainder_d   = 7'd0;
          div_by_zero_d = 1'b1;
          ovf_d         = 1'b0;
        end else begin
          div_by_zero_d = 1'b0;
          remainder_d   = neg_r_q ? 7'd0 - rem_q : rem_q;
`ifdef CNN_DIV_SAT_EN
          if (q_full > 22'sd8191) begin
            quotient_d = 14'h1FFF;
            ovf_d      = 1'b1;
          end else if (q_full < -22'sd8192) begin
            quotient_d = 14'h2000;
            ovf_d      = 1'b1;
          end else begin
            quotient_d = q_full[13:0];
            ovf_d      = 1'b0;
          end
`else
          quotient_d = 14'(neg_q_q ? 21'd0 - dvd_q : dvd_q);
          ovf_d      = 1'b0;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 5'd0;
      dvd_q         <= 21'd0;
      rem_q         <= 7'd0;
      dvs_q         <= 8'd0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      quotient_q    <= 14'd0;
      remainder_q   <= 7'd0;
      div_by_zero_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      rem_q         <= rem_d;
      dvs_q         <= dvs_d;
      neg_q_q       <= neg_q_d;
      neg_r_q       <= neg_r_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.ap_idle     = (state_q == S_IDLE);
  assign bus.ap_ready    = (state_q == S_IDLE) && bus.ap_start;
  assign bus.ap_done     = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_cnn_div_seq_21s_7s.sv
// Self-checking bench for cnn_div_seq_21s_7s: arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations and latency checks.
module tb_cnn_div_seq_21s_7s;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  cnn_div_seq_21s_7s_if bus ();

  cnn_div_seq_21s_7s #(.ID(32'd1)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: C-style truncating division, then the 14-bit overflow policy.
  function automatic void model_div(input int a, input int b, output int q, output int r,
                                    output bit dz, output bit ov);
    int qt;
    logic signed [13:0] w;
    if (b == 0) begin
      q = 0; r = 0; dz = 1'b1; ov = 1'b0;
    end else begin
      qt = a / b;
      r  = a % b;
      dz = 1'b0;
`ifdef CNN_DIV_SAT_EN
      if (qt > 8191)       begin q = 8191;  ov = 1'b1; end
      else if (qt < -8192) begin q = -8192; ov = 1'b1; end
      else                 begin q = qt;    ov = 1'b0; end
`else
      w  = qt[13:0];
      q  = w;
      ov = 1'b0;
`endif
    end
  endfunction

  // Model state: cycle count of the accept edge plus 22 marks DONE entry.
  bit m_idle   = 1'b1;
  int cyc      = 0;
  int done_cyc = -100;
  int p_q = 0, p_r = 0;
  bit p_dz = 1'b0, p_ovf = 1'b0;
  int e_q = 0, e_r = 0;
  bit e_dz = 1'b0, e_ovf = 1'b0;

  always @(posedge ap_rst) begin
    m_idle = 1'b1; done_cyc = -100;
    e_q = 0; e_r = 0; e_dz = 1'b0; e_ovf = 1'b0;
  end

  always @(posedge ap_clk) begin
    cyc++;
    if (ap_rst) begin
      m_idle = 1'b1; done_cyc = -100;
      e_q = 0; e_r = 0; e_dz = 1'b0; e_ovf = 1'b0;
    end else begin
      if (m_idle) begin
        if (bus.ap_start) begin
          m_idle   = 1'b0;
          done_cyc = cyc + 22;
          model_div($signed(bus.dividend), $signed(bus.divisor), p_q, p_r, p_dz, p_ovf);
        end
      end else if (cyc == done_cyc + 1) begin
        m_idle = 1'b1;
      end
      if (cyc == done_cyc) begin
        e_q = p_q; e_r = p_r; e_dz = p_dz; e_ovf = p_ovf;
      end
    end
  end

  always @(negedge ap_clk) begin
    check("idle",        bus.ap_idle,            m_idle);
    check("ready",       bus.ap_ready,           m_idle & bus.ap_start);
    check("done",        bus.ap_done,            !m_idle && (cyc == done_cyc));
    check("quotient",    $signed(bus.quotient),  e_q);
    check("remainder",   $signed(bus.remainder), e_r);
    check("div_by_zero", bus.div_by_zero,        e_dz);
    check("ovf",         bus.ovf,                e_ovf);
  end

  // Waits for ap_done; cycle 1 is the first cycle after the accept edge.
  task automatic wait_done(input string tag, input int swap_at, input int sa, input int sb);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge ap_clk);
      if (i == swap_at) begin
        bus.dividend = 21'(sa);
        bus.divisor  = 7'(sb);
      end
      if (bus.ap_done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, 23);
  endtask

  task automatic run_div(input int a, input int b, input int xq, input int xr,
                         input bit xdz, input bit xovf, input string tag);
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    bus.dividend = 21'(a);
    bus.divisor  = 7'(b);
    #1 check({tag, " ready"}, bus.ap_ready, 1);
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    wait_done(tag, 0, 0, 0);
    check({tag, " q"},   $signed(bus.quotient),  xq);
    check({tag, " r"},   $signed(bus.remainder), xr);
    check({tag, " dz"},  bus.div_by_zero,        xdz);
    check({tag, " ovf"}, bus.ovf,                xovf);
  endtask

  initial begin
    int dones;
    bus.ap_start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(posedge ap_clk);
    #1;
    check("rst idle", bus.ap_idle, 1);
    check("rst done", bus.ap_done, 0);
    check("rst q",    $signed(bus.quotient), 0);
    bus.ap_start = 1'b1;
    #1 check("rst ready follows start", bus.ap_ready, 1);
    bus.ap_start = 1'b0;
    @(posedge ap_clk); #1 ap_rst = 1'b0;

    run_div(1000, 7, 142, 6, 0, 0, "pos");
    run_div(-1000, 7, -142, -6, 0, 0, "negdvd");
    run_div(1000, -7, -142, 6, 0, 0, "negdvs");
    run_div(-1000, -64, 15, -40, 0, 0, "m64");
    run_div(63, -64, 0, 63, 0, 0, "small");
`ifdef CNN_DIV_SAT_EN
    run_div(1048575, 1, 8191, 0, 0, 1, "maxpos");
    run_div(-1048576, -1, 8191, 0, 0, 1, "minneg");
    run_div(-1048576, 7, -8192, -4, 0, 1, "minsat");
`else
    run_div(1048575, 1, -1, 0, 0, 0, "maxpos");
    run_div(-1048576, -1, 0, 0, 0, 0, "minneg");
    run_div(-1048576, 7, -2340, -4, 0, 0, "minwrap");
`endif
    run_div(500, 0, 0, 0, 1, 0, "dz");
    run_div(500, 5, 100, 0, 0, 0, "after dz");

    // ap_start held high; operands change mid-calculation and must not leak in.
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    bus.dividend = 21'(1000);
    bus.divisor  = 7'(7);
    @(posedge ap_clk);
    wait_done("busy", 5, 300, -9);
    check("busy q", $signed(bus.quotient), 142);
    check("busy r", $signed(bus.remainder), 6);
    @(negedge ap_clk);
    check("b2b ready", bus.ap_ready, 1);
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    wait_done("b2b", 0, 0, 0);
    check("b2b q", $signed(bus.quotient), -33);
    check("b2b r", $signed(bus.remainder), 3);

    // Reset mid-CALC discards the operation.
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    bus.dividend = 21'(1000);
    bus.divisor  = 7'(7);
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    check("midrst idle", bus.ap_idle, 1);
    check("midrst q",    $signed(bus.quotient), 0);
    check("midrst r",    $signed(bus.remainder), 0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (bus.ap_done) dones++;
    end
    check("midrst no done", dones, 0);
    run_div(1000, 7, 142, 6, 0, 0, "post rst");

    repeat (3) @(posedge ap_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
